// File: rtl/motor_ramp_ctrl.sv
// N-channel DC motor driver: ramps the applied duty toward a per-channel target,
// stops and waits out a dead time on reversal, and drives PWM plus H-bridge IN pins.

module motor_ramp_ch #(
    parameter int DUTY_W     = 10,
    parameter int PERIOD     = 4000,
    parameter int CNT_W      = 12,
    parameter int RAMP_STEP  = 8,
    parameter int DEAD_TICKS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              estop,
    input  logic              tick,
    input  logic              cnt_zero,
    input  logic [CNT_W-1:0]  count,
    input  logic              tgt_dir,
    input  logic [DUTY_W-1:0] tgt_duty,
    output logic              pwm,
    output logic              in_a,
    output logic              in_b,
    output logic              at_target,
    output logic              busy
);
    localparam int DC_W = $clog2(DEAD_TICKS + 1);
    localparam logic [DUTY_W-1:0] STEP = DUTY_W'(RAMP_STEP);

    typedef enum logic [1:0] {IDLE, RUN, DECEL, DEAD} state_t;

    state_t            state, state_n;
    logic [DUTY_W-1:0] duty, duty_n;
    logic              cur_dir, dir_n;
    logic [DC_W-1:0]   dead_cnt, dead_n;
    logic [CNT_W-1:0]  cmp, cmp_nxt;
    logic [31:0]       prod;
    logic              drive_n, at_target_n;

    always_comb begin
        state_n = state;
        duty_n  = duty;
        dir_n   = cur_dir;
        dead_n  = dead_cnt;
        if (estop) begin
            state_n = IDLE;
            duty_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    duty_n = '0;
                    if (tgt_duty != '0) begin
                        dir_n   = tgt_dir;
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (tgt_dir != cur_dir && tgt_duty != '0) begin
                        state_n = DECEL;
                    end else if (duty == '0 && tgt_duty == '0) begin
                        state_n = IDLE;
                    end else if (tick) begin
                        // differences are compared first so the step never wraps
                        if (duty < tgt_duty)
                            duty_n = (tgt_duty - duty > STEP) ? duty + STEP : tgt_duty;
                        else if (duty > tgt_duty)
                            duty_n = (duty - tgt_duty > STEP) ? duty - STEP : tgt_duty;
                    end
                end
                DECEL: begin
                    if (duty == '0) begin
                        state_n = DEAD;
                        dead_n  = DC_W'(DEAD_TICKS);
                    end else if (tick) begin
                        duty_n = (duty > STEP) ? duty - STEP : '0;
                    end
                end
                DEAD: begin
                    if (dead_cnt == '0) begin
                        if (tgt_duty != '0) begin
                            dir_n   = tgt_dir;
                            state_n = RUN;
                        end else begin
                            state_n = IDLE;
                        end
                    end else if (tick) begin
                        dead_n = dead_cnt - DC_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // DECEL keeps the old direction applied while the duty bleeds off
    assign drive_n     = (state_n == RUN) || (state_n == DECEL);
    assign at_target_n = (state == RUN && duty == tgt_duty && cur_dir == tgt_dir) ||
                         (state == IDLE && tgt_duty == '0);
    assign prod        = 32'(PERIOD) * 32'(duty);
    assign cmp_nxt     = cnt_zero ? CNT_W'(prod >> DUTY_W) : cmp;
    assign busy        = (state == DECEL) || (state == DEAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            duty      <= '0;
            cur_dir   <= 1'b0;
            dead_cnt  <= '0;
            cmp       <= '0;
            pwm       <= 1'b0;
            in_a      <= 1'b0;
            in_b      <= 1'b0;
            at_target <= 1'b0;
        end else begin
            state     <= state_n;
            duty      <= duty_n;
            cur_dir   <= dir_n;
            dead_cnt  <= dead_n;
            cmp       <= cmp_nxt;
            pwm       <= !estop && (count < cmp_nxt);
            in_a      <= drive_n && dir_n;
            in_b      <= drive_n && !dir_n;
            at_target <= at_target_n;
        end
    end
endmodule

module motor_ramp_ctrl #(
    parameter int CH         = 2,
    parameter int DUTY_W     = 10,
    parameter int CLK_HZ     = 100_000_000,
    parameter int PWM_HZ     = 25_000,
    parameter int RAMP_DIV   = 100_000,
    parameter int RAMP_STEP  = 8,
    parameter int DEAD_TICKS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 estop,
    input  logic [CH-1:0]        target_dir,
    input  logic [CH*DUTY_W-1:0] target_duty,
    output logic [CH-1:0]        pwm,
    output logic [CH-1:0]        in_a,
    output logic [CH-1:0]        in_b,
    output logic [CH-1:0]        at_target,
    output logic                 busy
);
    localparam int PERIOD = CLK_HZ / PWM_HZ;
    localparam int CNT_W  = $clog2(PERIOD + 1);
    localparam int DIV_W  = $clog2(RAMP_DIV + 1);

    logic [CNT_W-1:0] count;
    logic [DIV_W-1:0] div;
    logic             tick, cnt_zero;
    logic [CH-1:0]    busy_ch;

    assign tick     = (div == DIV_W'(RAMP_DIV - 1));
    assign cnt_zero = (count == '0);
    assign busy     = |busy_ch;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            div   <= '0;
        end else begin
            count <= (count == CNT_W'(PERIOD - 1)) ? '0 : count + CNT_W'(1);
            div   <= tick ? '0 : div + DIV_W'(1);
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        motor_ramp_ch #(
            .DUTY_W(DUTY_W), .PERIOD(PERIOD), .CNT_W(CNT_W),
            .RAMP_STEP(RAMP_STEP), .DEAD_TICKS(DEAD_TICKS)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .estop    (estop),
            .tick     (tick),
            .cnt_zero (cnt_zero),
            .count    (count),
            .tgt_dir  (target_dir[g]),
            .tgt_duty (target_duty[g*DUTY_W +: DUTY_W]),
            .pwm      (pwm[g]),
            .in_a     (in_a[g]),
            .in_b     (in_b[g]),
            .at_target(at_target[g]),
            .busy     (busy_ch[g])
        );
    end
endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed and randomized checks of motor_ramp_ctrl against timing and duty figures
// derived from the ramp/tick/period arithmetic.

module tb_motor_ramp_ctrl;
    localparam int CH = 2, DUTY_W = 10, RAMP_DIV = 4, STEP = 8, DEAD = 5;
    localparam int PERIOD = 100_000_000 / 25_000;

    logic                 clk = 1'b0;
    logic                 rst, estop;
    logic [CH-1:0]        target_dir;
    logic [CH*DUTY_W-1:0] target_duty;
    logic [CH-1:0]        pwm, in_a, in_b, at_target;
    logic                 busy;

    motor_ramp_ctrl #(
        .CH(CH), .DUTY_W(DUTY_W), .CLK_HZ(100_000_000), .PWM_HZ(25_000),
        .RAMP_DIV(RAMP_DIV), .RAMP_STEP(STEP), .DEAD_TICKS(DEAD)
    ) dut (
        .clk(clk), .rst(rst), .estop(estop), .target_dir(target_dir),
        .target_duty(target_duty), .pwm(pwm), .in_a(in_a), .in_b(in_b),
        .at_target(at_target), .busy(busy)
    );

    always #5 clk = ~clk;

    int n;       // edges since the last reset edge
    int n_chk = 0, n_pass = 0;

    task automatic step();
        @(posedge clk);
        if (rst) n = 0; else n++;
        #1;
    endtask

    task automatic steps(input int k);
        repeat (k) step();
    endtask

    task automatic step_to(input int m);
        while (n < m) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic set_tgt(input int c, input logic dir, input int d);
        target_dir[c] = dir;
        target_duty[c*DUTY_W +: DUTY_W] = DUTY_W'(d);
    endtask

    function automatic logic [1:0] pins(input int c);
        return {in_a[c], in_b[c]};
    endfunction

    // first ramp tick strictly after edge e (ticks land on edges that are multiples of RAMP_DIV)
    function automatic int first_tick(input int e);
        return (e / RAMP_DIV + 1) * RAMP_DIV;
    endfunction

    function automatic int nticks(input int d);
        return (d + STEP - 1) / STEP;
    endfunction

    function automatic int cmp_of(input int d);
        return (PERIOD * d) >> DUTY_W;
    endfunction

    // high cycles over one full period, starting at the next compare latch
    task automatic pwm_period(output int h0, output int h1);
        while ((n - 1) % PERIOD != 0) step();
        h0 = 0; h1 = 0;
        repeat (PERIOD) begin
            h0 += int'(pwm[0]);
            h1 += int'(pwm[1]);
            step();
        end
    endtask

    initial begin
        int h0, h1, t_hit, t50, t55, r, e, mid_hi;
        int m_duty[CH], wait_cyc, t, d;
        logic m_dir[CH];
        logic dr;

        rst = 1'b1; estop = 1'b0; target_dir = '0; target_duty = '0; n = 0;
        steps(3);
        chk("rst_pwm", pwm, 0);
        chk("rst_in_a", in_a, 0);
        chk("rst_in_b", in_b, 0);
        chk("rst_at_target", at_target, 0);
        chk("rst_busy", busy, 0);

        // ramp-up 0 -> 800 forward, starting right out of reset
        rst = 1'b0;
        set_tgt(0, 1'b0, 800);
        t_hit = first_tick(1) + RAMP_DIV * (nticks(800) - 1);
        step_to(t_hit);
        chk("ramp_at_before", at_target[0], 0);
        step();
        chk("ramp_at_after", at_target[0], 1);
        chk("ramp_pins0", pins(0), 2'b01);
        chk("ramp_pins1_idle", pins(1), 2'b00);
        chk("ramp_at1_idle", at_target[1], 1);
        chk("ramp_busy", busy, 0);

        pwm_period(h0, h1);
        chk("pwm_800", h0, cmp_of(800));
        chk("pwm_ch1_zero", h1, 0);

        set_tgt(0, 1'b0, 512);
        steps(200);
        pwm_period(h0, h1);
        chk("pwm_512", h0, cmp_of(512));

        // target drops to 0 a little into the period; this period's compare must hold
        while ((n - 1) % PERIOD != 0) step();
        mid_hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (i == 100) set_tgt(0, 1'b0, 0);
            mid_hi += int'(pwm[0]);
            step();
        end
        chk("pwm_mid_change", mid_hi, cmp_of(512));
        pwm_period(h0, h1);
        chk("pwm_duty0", h0, 0);
        chk("duty0_pins", pins(0), 2'b00);
        chk("duty0_at", at_target[0], 1);

        // saturation at the low end and an exact landing near full scale
        set_tgt(0, 1'b0, 5);
        steps(3 * RAMP_DIV);
        pwm_period(h0, h1);
        chk("sat_pwm_5", h0, cmp_of(5));
        set_tgt(0, 1'b0, 0);
        steps(3 * RAMP_DIV);
        chk("sat_idle_pins", pins(0), 2'b00);
        chk("sat_idle_at", at_target[0], 1);
        set_tgt(0, 1'b0, 1020);
        steps((nticks(1020) + 2) * RAMP_DIV);
        chk("sat_1020_at", at_target[0], 1);
        pwm_period(h0, h1);
        chk("sat_pwm_1020", h0, cmp_of(1020));

        // estop at duty 600
        set_tgt(0, 1'b0, 600);
        steps((nticks(1020 - 600) + 2) * RAMP_DIV);
        chk("pre_estop_at", at_target[0], 1);
        estop = 1'b1;
        step();
        chk("estop_pwm", pwm, 0);
        chk("estop_in_a", in_a, 0);
        chk("estop_in_b", in_b, 0);
        chk("estop_busy", busy, 0);
        steps(PERIOD + 10);
        chk("estop_pwm_hold", pwm, 0);
        estop = 1'b0;
        r = n + 1;
        t_hit = first_tick(r) + RAMP_DIV * (nticks(600) - 1);
        step();
        chk("estop_rel_pins", pins(0), 2'b01);
        step_to(t_hit);
        chk("estop_ramp_before", at_target[0], 0);
        step();
        chk("estop_ramp_after", at_target[0], 1);

        // reversal 400 forward -> 400 reverse
        set_tgt(0, 1'b0, 400);
        steps((nticks(200) + 2) * RAMP_DIV);
        chk("rev_pre_at", at_target[0], 1);
        set_tgt(0, 1'b1, 400);
        e = n + 1;
        t50 = first_tick(e) + RAMP_DIV * (nticks(400) - 1);
        t55 = t50 + RAMP_DIV * DEAD;
        step();
        chk("rev_decel_busy", busy, 1);
        step_to(t50);
        chk("rev_decel_end_pins", pins(0), 2'b01);
        chk("rev_decel_end_busy", busy, 1);
        step();
        chk("rev_dead_pins", pins(0), 2'b00);
        chk("rev_dead_busy", busy, 1);
        step_to(t55);
        chk("rev_dead_end_pins", pins(0), 2'b00);
        chk("rev_dead_end_busy", busy, 1);
        step();
        chk("rev_run_pins", pins(0), 2'b10);
        chk("rev_run_busy", busy, 0);
        t_hit = first_tick(t55 + 1) + RAMP_DIV * (nticks(400) - 1);
        step_to(t_hit);
        chk("rev_at_before", at_target[0], 0);
        step();
        chk("rev_at_after", at_target[0], 1);

        // reset in the middle of a deceleration
        set_tgt(0, 1'b0, 400);
        steps(11);
        chk("rst_decel_busy", busy, 1);
        rst = 1'b1;
        step();
        chk("rst2_pwm", pwm, 0);
        chk("rst2_in_a", in_a, 0);
        chk("rst2_in_b", in_b, 0);
        chk("rst2_at", at_target, 0);
        chk("rst2_busy", busy, 0);
        rst = 1'b0;
        step();
        chk("rst2_restart_pins", pins(0), 2'b01);
        t_hit = first_tick(1) + RAMP_DIV * (nticks(400) - 1);
        step_to(t_hit);
        chk("rst2_at_before", at_target[0], 0);
        step();
        chk("rst2_at_after", at_target[0], 1);

        // random targets on both channels, judged by settled state and PWM width
        m_duty[0] = 400; m_dir[0] = 1'b0;
        m_duty[1] = 0;   m_dir[1] = 1'b0;
        for (int it = 0; it < 3; it++) begin
            wait_cyc = 0;
            for (int c = 0; c < CH; c++) begin
                d  = int'($urandom_range(0, 1023));
                dr = 1'($urandom_range(0, 1));
                if (m_duty[c] == 0)      t = nticks(d);
                else if (d == 0)         t = nticks(m_duty[c]);
                else if (dr == m_dir[c]) t = nticks(d > m_duty[c] ? d - m_duty[c] : m_duty[c] - d);
                else                     t = nticks(m_duty[c]) + DEAD + nticks(d) + 3;
                if ((t + 3) * RAMP_DIV > wait_cyc) wait_cyc = (t + 3) * RAMP_DIV;
                m_duty[c] = d;
                if (d != 0) m_dir[c] = dr;
                set_tgt(c, dr, d);
            end
            steps(wait_cyc);
            chk("rnd_busy", busy, 0);
            for (int c = 0; c < CH; c++) begin
                chk($sformatf("rnd%0d_at%0d", it, c), at_target[c], 1);
                chk($sformatf("rnd%0d_pins%0d", it, c), pins(c),
                    m_duty[c] == 0 ? 2'b00 : (m_dir[c] ? 2'b10 : 2'b01));
            end
            pwm_period(h0, h1);
            chk($sformatf("rnd%0d_pwm0", it), h0, cmp_of(m_duty[0]));
            chk($sformatf("rnd%0d_pwm1", it), h1, cmp_of(m_duty[1]));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/motor_ramp_ctrl.md
Name: motor_ramp_ctrl

Overview:
- Parametrised N-channel DC motor driver that replaces the fixed-speed, fixed-direction motor block.
- Takes a per-channel target direction and duty, slews the applied duty toward the target at a bounded ramp rate, and inserts a stop-then-dead-time sequence on every direction reversal.
- Drives per-channel PWM and H-bridge IN pins from a single shared PWM period counter.
- Sits between the mode/decision logic and the motor driver pins.

Parameters:
- CH, 2, number of motor channels
- DUTY_W, 10, duty width; duty full scale is 2^DUTY_W
- CLK_HZ, 100_000_000, clk frequency
- PWM_HZ, 25_000, PWM frequency; PERIOD = CLK_HZ/PWM_HZ (4000 at defaults)
- RAMP_DIV, 100_000, clk cycles per ramp tick
- RAMP_STEP, 8, maximum duty change per ramp tick
- DEAD_TICKS, 5, ramp ticks with IN=00 between a stop and the new direction

Ports:
- clk, input, 1, system clock
- rst, input, 1, synchronous active-high reset
- estop, input, 1, emergency stop, level-sensitive
- target_dir, input, CH, per-channel direction; 0 = forward, 1 = reverse
- target_duty, input, CH*DUTY_W, per-channel target duty; channel i occupies bits [i*DUTY_W +: DUTY_W]
- pwm, output, CH, per-channel PWM
- in_a, output, CH, H-bridge IN1 per channel
- in_b, output, CH, H-bridge IN2 per channel
- at_target, output, CH, applied duty and direction equal the target
- busy, output, 1, OR over all channels of state in {DECEL, DEAD}

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, named clk and rst.
- Reset values:
  - pwm, in_a, in_b, busy = 0; at_target = 0.
  - All channel states = IDLE; all duty and compare registers = 0.
  - Period counter and ramp divider = 0.
- Period counter: runs 0..PERIOD-1, then wraps to 0.
- PWM compare latch: at count==0, each channel latches cmp = (PERIOD*duty) >> DUTY_W.
  - Use 32-bit intermediate arithmetic and truncate.
  - Duty changes never take effect mid-period.
- PWM output: registered, pwm <= (count < cmp).
  - duty=0 gives constant 0.
  - Maximum duty gives PERIOD-1-style near-100%; output is never stuck high.
- Ramp tick: single-cycle pulse when the divider reaches RAMP_DIV-1; the divider then wraps to 0. The tick is shared by all channels.
- Direction encoding: forward gives {in_a,in_b} = 01; reverse gives 10; IDLE and DEAD give 00.
  - IN pins are registered and change in the same cycle as the state update.
- Per-channel FSM (duty = applied duty, cur_dir = latched direction):
  - IDLE: duty=0, IN=00. If target_duty != 0, latch cur_dir = target_dir and go to RUN; duty is still 0.
  - RUN, tgt_dir == cur_dir: on tick, duty = min(duty+RAMP_STEP, tgt) if below tgt, or max(duty-RAMP_STEP, tgt) if above. Saturating; no wrap.
    - Leave RUN for IDLE when duty==0 and tgt==0, evaluated every cycle.
  - RUN, tgt_dir != cur_dir and tgt != 0: go to DECEL.
  - DECEL: on tick, duty = max(duty-RAMP_STEP, 0). When duty==0, go to DEAD, load dead_cnt = DEAD_TICKS, set IN=00.
    - A target change during DECEL does not abort DECEL.
  - DEAD: on tick, decrement dead_cnt. When dead_cnt==0:
    - If tgt != 0, latch cur_dir = target_dir and go to RUN.
    - Otherwise go to IDLE.
- estop: while high, every channel is forced to IDLE with duty=0 and IN=00 in the next cycle, overriding all other logic.
  - pwm falls at the next period start, when cmp latches 0.
  - pwm is also gated to 0 combinationally before its output register, so it falls within 1 cycle.
  - On release, normal ramping resumes from 0.
- at_target: 1 when state is RUN with duty==tgt and cur_dir==tgt_dir, or when state is IDLE with tgt==0. Registered; 1-cycle latency.
- Targets are sampled every cycle; there is no handshake.
- Channels are fully independent apart from the shared counters.

Test Plan:
- Ramp-up (RAMP_DIV=4, RAMP_STEP=8, ch0 target 0 -> 800 forward): 100 ticks to reach 800, at_target rises one cycle after the 100th tick, {in_a,in_b}[0]=01; ch1 stays IDLE.
- PWM accuracy (duty held at 512): exactly 2000 high cycles per 4000-cycle period; duty 0 gives no high cycles; a duty change mid-period applies only from the next count==0.
- Reversal (RUN 400 forward, then target_dir=1, target 400):
  - DECEL lasts 50 ticks, then IN=00 for 5 ticks with busy=1.
  - Then IN=10 and the ramp back to 400, after which at_target=1.
- Saturation (duty 5, target 0, STEP 8): duty goes 5 -> 0 (not negative), then IDLE; a 1020 target on a 1023 scale ends exactly at 1020.
- estop asserted at duty 600: pwm and IN are 0 within 1 cycle, state is IDLE; on release with target 600, the ramp restarts from 0.
- rst asserted mid-DECEL for 1 cycle: all outputs, counters and states return to reset values on the next edge.
